// File: rtl/vmd_msix_bar_core.sv
`default_nettype none
// ============================================================================
// vmd_msix_bar_core - VMD function-0 BAR: CSRs, MSI-X table/PBA, message dispatch
// Revision 1.0
// ============================================================================
module vmd_msix_bar_core #(
    parameter int          NUM_VECTORS = 8,
    parameter logic [31:0] ID_VALUE    = 32'h201D8086
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wr_addr,
    input  logic [3:0]  wr_be,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    input  logic [87:0] rd_req_ctx,
    input  logic [31:0] rd_req_addr,
    input  logic        rd_req_valid,
    output logic [87:0] rd_rsp_ctx,
    output logic [31:0] rd_rsp_data,
    output logic        rd_rsp_valid,
    output logic        msix_interrupt_valid,
    output logic [63:0] msix_interrupt_addr,
    output logic [31:0] msix_interrupt_data,
    output logic        msix_interrupt_error
);

    localparam logic [9:0] c_IDX_ID      = 10'h000;
    localparam logic [9:0] c_IDX_CTRL    = 10'h001;
    localparam logic [9:0] c_IDX_STATUS  = 10'h002;
    localparam logic [9:0] c_IDX_TRIGGER = 10'h003;
    localparam logic [9:0] c_IDX_SCRATCH = 10'h004;
    localparam logic [9:0] c_IDX_ERRCNT  = 10'h005;
    localparam logic [9:0] c_IDX_PBA     = 10'h300;

    logic [1:0]             r_ctrl;
    logic [NUM_VECTORS-1:0] r_status;
    logic [NUM_VECTORS-1:0] r_pba;
    logic [NUM_VECTORS-1:0] r_mask;
    logic [31:0]            r_scratch;
    logic [15:0]            r_errcnt;
    logic [31:0]            r_tbl_lo   [NUM_VECTORS];
    logic [31:0]            r_tbl_hi   [NUM_VECTORS];
    logic [31:0]            r_tbl_data [NUM_VECTORS];

    logic [31:0]            w_be_mask;
    logic [9:0]             w_wr_idx;
    logic                   w_wr_tbl;
    logic [NUM_VECTORS-1:0] w_trig;
    logic [NUM_VECTORS-1:0] w_clr;
    logic [NUM_VECTORS-1:0] w_elig;
    logic [NUM_VECTORS-1:0] w_sel;
    logic                   w_found;
    logic                   w_bad;
    logic [63:0]            w_cand_addr;
    logic [31:0]            w_cand_data;
    logic [31:0]            w_rd_data;
    logic                   w_unused_bits;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    assign w_be_mask = {{8{wr_be[3]}}, {8{wr_be[2]}}, {8{wr_be[1]}}, {8{wr_be[0]}}};
    assign w_wr_idx  = wr_addr[11:2];
    assign w_wr_tbl  = wr_valid && (wr_addr[11:10] == 2'b10);
    assign w_trig    = (wr_valid && w_wr_idx == c_IDX_TRIGGER) ?
                       (wr_data[NUM_VECTORS-1:0] & w_be_mask[NUM_VECTORS-1:0]) : '0;
    assign w_clr     = (wr_valid && w_wr_idx == c_IDX_STATUS) ?
                       (wr_data[NUM_VECTORS-1:0] & w_be_mask[NUM_VECTORS-1:0]) : '0;
    assign w_unused_bits = ^{wr_addr[31:12], wr_addr[1:0], rd_req_addr[31:12], rd_req_addr[1:0]};

    // Lowest eligible vector wins; loop runs downward so the last hit is the lowest index.
    always_comb begin
        w_elig      = r_pba & ~r_mask & {NUM_VECTORS{r_ctrl[0] & ~r_ctrl[1]}};
        w_found     = 1'b0;
        w_sel       = '0;
        w_cand_addr = '0;
        w_cand_data = '0;
        for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_found     = 1'b1;
                w_sel       = '0;
                w_sel[i]    = 1'b1;
                w_cand_addr = {r_tbl_hi[i], r_tbl_lo[i]};
                w_cand_data = r_tbl_data[i];
            end
        end
        w_bad = (w_cand_addr == 64'd0) || (w_cand_addr[1:0] != 2'b00);
    end

    always_comb begin
        w_rd_data = '0;
        case (rd_req_addr[11:2])
            c_IDX_ID:      w_rd_data = ID_VALUE;
            c_IDX_CTRL:    w_rd_data = {30'd0, r_ctrl};
            c_IDX_STATUS:  w_rd_data = 32'(r_status);
            c_IDX_SCRATCH: w_rd_data = r_scratch;
            c_IDX_ERRCNT:  w_rd_data = {16'd0, r_errcnt};
            c_IDX_PBA:     w_rd_data = 32'(r_pba);
            default:       w_rd_data = '0;
        endcase
        if (rd_req_addr[11:10] == 2'b10) begin
            for (int i = 0; i < NUM_VECTORS; i++) begin
                if (rd_req_addr[9:4] == 6'(i)) begin
                    case (rd_req_addr[3:2])
                        2'd0:    w_rd_data = r_tbl_lo[i];
                        2'd1:    w_rd_data = r_tbl_hi[i];
                        2'd2:    w_rd_data = r_tbl_data[i];
                        default: w_rd_data = {31'd0, r_mask[i]};
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ctrl    <= '0;
            r_status  <= '0;
            r_pba     <= '0;
            r_mask    <= '1;
            r_scratch <= '0;
            r_errcnt  <= '0;
            for (int i = 0; i < NUM_VECTORS; i++) begin
                r_tbl_lo[i]   <= '0;
                r_tbl_hi[i]   <= '0;
                r_tbl_data[i] <= '0;
            end
        end else begin
            if (wr_valid && w_wr_idx == c_IDX_CTRL && wr_be[0]) begin
                r_ctrl <= wr_data[1:0];
            end
            if (wr_valid && w_wr_idx == c_IDX_SCRATCH) begin
                r_scratch <= f_merge(r_scratch, wr_data, w_be_mask);
            end
            // Set terms are OR'd last so a trigger beats a same-cycle clear or dispatch.
            r_status <= (r_status & ~w_clr) | w_trig;
            r_pba    <= (r_pba & ~w_sel) | w_trig;
            if (w_found && w_bad && r_errcnt != 16'hFFFF) begin
                r_errcnt <= r_errcnt + 16'd1;
            end
            for (int i = 0; i < NUM_VECTORS; i++) begin
                if (w_wr_tbl && wr_addr[9:4] == 6'(i)) begin
                    case (wr_addr[3:2])
                        2'd0:    r_tbl_lo[i]   <= f_merge(r_tbl_lo[i], wr_data, w_be_mask);
                        2'd1:    r_tbl_hi[i]   <= f_merge(r_tbl_hi[i], wr_data, w_be_mask);
                        2'd2:    r_tbl_data[i] <= f_merge(r_tbl_data[i], wr_data, w_be_mask);
                        default: if (wr_be[0]) r_mask[i] <= wr_data[0];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_rsp_valid         <= 1'b0;
            rd_rsp_ctx           <= '0;
            rd_rsp_data          <= '0;
            msix_interrupt_valid <= 1'b0;
            msix_interrupt_error <= 1'b0;
            msix_interrupt_addr  <= '0;
            msix_interrupt_data  <= '0;
        end else begin
            rd_rsp_valid         <= rd_req_valid;
            rd_rsp_ctx           <= rd_req_valid ? rd_req_ctx : '0;
            rd_rsp_data          <= rd_req_valid ? w_rd_data : '0;
            msix_interrupt_valid <= w_found && !w_bad;
            msix_interrupt_error <= w_found && w_bad;
            msix_interrupt_addr  <= (w_found && !w_bad) ? w_cand_addr : '0;
            msix_interrupt_data  <= (w_found && !w_bad) ? w_cand_data : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vmd_msix_bar_core.sv
`default_nettype none
// ============================================================================
// tb_vmd_msix_bar_core - scoreboard bench for the VMD function-0 BAR block
// Revision 1.0
// ============================================================================
module tb_vmd_msix_bar_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [3:0]  wr_be = '0;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic [87:0] rd_req_ctx = '0;
    logic [31:0] rd_req_addr = '0;
    logic        rd_req_valid = 1'b0;
    logic [87:0] rd_rsp_ctx;
    logic [31:0] rd_rsp_data;
    logic        rd_rsp_valid;
    logic        msix_interrupt_valid;
    logic [63:0] msix_interrupt_addr;
    logic [31:0] msix_interrupt_data;
    logic        msix_interrupt_error;

    vmd_msix_bar_core #(.NUM_VECTORS(8), .ID_VALUE(32'h201D8086)) dut (
        .clk(clk), .rst(rst),
        .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_valid(wr_valid),
        .rd_req_ctx(rd_req_ctx), .rd_req_addr(rd_req_addr), .rd_req_valid(rd_req_valid),
        .rd_rsp_ctx(rd_rsp_ctx), .rd_rsp_data(rd_rsp_data), .rd_rsp_valid(rd_rsp_valid),
        .msix_interrupt_valid(msix_interrupt_valid), .msix_interrupt_addr(msix_interrupt_addr),
        .msix_interrupt_data(msix_interrupt_data), .msix_interrupt_error(msix_interrupt_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] cyc;
        logic [87:0] ctx;
        logic [31:0] data;
    } rsp_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic        v;
        logic        e;
        logic [63:0] addr;
        logic [31:0] data;
    } irq_t;

    rsp_t exp_q[$];
    rsp_t obs_q[$];
    irq_t irq_q[$];
    irq_t exp_irq[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Advance to the next falling edge and record whatever the DUT produced.
    task automatic tick();
        @(negedge clk);
        if (rd_rsp_valid) obs_q.push_back('{cyc, rd_rsp_ctx, rd_rsp_data});
        if (msix_interrupt_valid || msix_interrupt_error)
            irq_q.push_back('{cyc, msix_interrupt_valid, msix_interrupt_error,
                              msix_interrupt_addr, msix_interrupt_data});
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        logic [87:0] c;
        c = {24'($urandom), $urandom, $urandom};
        rd_req_valid = 1'b1; rd_req_addr = a; rd_req_ctx = c;
        exp_q.push_back('{cyc + 1, c, e});
        tick();
        rd_req_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0; wr_valid = 1'b0; rd_req_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        exp_q.delete(); obs_q.delete(); irq_q.delete(); exp_irq.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({rd_rsp_valid, msix_interrupt_valid, msix_interrupt_error} !== 3'b000 ||
            rd_rsp_data !== 32'd0 || rd_rsp_ctx !== 88'd0 ||
            msix_interrupt_addr !== 64'd0 || msix_interrupt_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got rsp_v %b irq_v %b err %b data %h, expected all zero",
                     rd_rsp_valid, msix_interrupt_valid, msix_interrupt_error, rd_rsp_data);
        end
        rd(32'h000, 32'h201D8086);
        rd(32'hC00, 32'h0);
        rd(32'h80C, 32'h1);
        rd(32'h87C, 32'h1);
        rd(32'h004, 32'h0);
        rd(32'h014, 32'h0);
        for (int w = 0; w < 4 && obs_q.size() < exp_q.size(); w++) tick();
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL reset_rsp_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            rsp_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL reset_rd: got data %h ctx %h cyc %0d, expected data %h ctx %h cyc %0d",
                         o.data, o.ctx, o.cyc, e.data, e.ctx, e.cyc);
            end
        end
    endtask

    task automatic test_byte_enables();
        logic [87:0] c;
        do_reset();
        wr(32'h010, 32'hAABBCCDD, 4'b0101);
        rd(32'h010, 32'h00BB00DD);
        // Read and write to the same address on the same cycle.
        c = {24'($urandom), $urandom, $urandom};
        wr_valid = 1'b1; wr_addr = 32'h010; wr_data = 32'h11111111; wr_be = 4'hF;
        rd_req_valid = 1'b1; rd_req_addr = 32'h010; rd_req_ctx = c;
        exp_q.push_back('{cyc + 1, c, 32'h00BB00DD});
        tick();
        wr_valid = 1'b0; rd_req_valid = 1'b0;
        rd(32'h010, 32'h11111111);
        wr(32'h004, 32'hFFFFFFFF, 4'hF);
        rd(32'h004, 32'h3);
        wr(32'h004, 32'h0, 4'b1110);
        rd(32'h004, 32'h3);
        wr(32'h810, 32'h12345678, 4'b1100);
        rd(32'h810, 32'h12340000);
        for (int w = 0; w < 4 && obs_q.size() < exp_q.size(); w++) tick();
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL be_rsp_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            rsp_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL be_rd: got data %h ctx %h cyc %0d, expected data %h ctx %h cyc %0d",
                         o.data, o.ctx, o.cyc, e.data, e.ctx, e.cyc);
            end
        end
    endtask

    task automatic test_status_rw1c();
        do_reset();
        wr(32'h00C, 32'h5, 4'hF);
        rd(32'h008, 32'h5);
        wr(32'h008, 32'h1, 4'hF);
        rd(32'h008, 32'h4);
        wr(32'h008, 32'h4, 4'b1110);
        rd(32'h008, 32'h4);
        wr(32'h00C, 32'h4, 4'hF);
        rd(32'h008, 32'h4);
        rd(32'h00C, 32'h0);
        rd(32'hC00, 32'h5);
        wr(32'h008, 32'hFFFFFFFF, 4'b0001);
        rd(32'h008, 32'h0);
        for (int w = 0; w < 4 && obs_q.size() < exp_q.size(); w++) tick();
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL status_rsp_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            rsp_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL status_rd: got data %h ctx %h cyc %0d, expected data %h ctx %h cyc %0d",
                         o.data, o.ctx, o.cyc, e.data, e.ctx, e.cyc);
            end
        end
    endtask

    task automatic test_dispatch();
        int k;
        do_reset();
        wr(32'h800, 32'hFEE00000, 4'hF);
        wr(32'h804, 32'h0, 4'hF);
        wr(32'h808, 32'h41, 4'hF);
        wr(32'h004, 32'h1, 4'hF);
        wr(32'h00C, 32'h1, 4'hF);
        repeat (3) tick();
        rd(32'hC00, 32'h1);
        k = cyc;
        wr(32'h80C, 32'h0, 4'hF);
        exp_irq.push_back('{k + 2, 1'b1, 1'b0, 64'h00000000FEE00000, 32'h41});
        repeat (4) tick();
        rd(32'hC00, 32'h0);
        rd(32'h008, 32'h1);
        n_vec++;
        if (irq_q.size() != exp_irq.size()) begin
            n_err++;
            $display("FAIL dispatch_irq_count: got %0d, expected %0d", irq_q.size(), exp_irq.size());
        end else begin
            foreach (irq_q[j]) begin
                n_vec++;
                if (irq_q[j] !== exp_irq[j]) begin
                    n_err++;
                    $display("FAIL dispatch_irq: got cyc %0d v %b e %b addr %h data %h, expected cyc %0d v %b e %b addr %h data %h",
                             irq_q[j].cyc, irq_q[j].v, irq_q[j].e, irq_q[j].addr, irq_q[j].data,
                             exp_irq[j].cyc, exp_irq[j].v, exp_irq[j].e, exp_irq[j].addr, exp_irq[j].data);
                end
            end
        end
        for (int w = 0; w < 4 && obs_q.size() < exp_q.size(); w++) tick();
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL dispatch_rsp_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            rsp_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL dispatch_rd: got data %h ctx %h cyc %0d, expected data %h ctx %h cyc %0d",
                         o.data, o.ctx, o.cyc, e.data, e.ctx, e.cyc);
            end
        end
    endtask

    task automatic test_func_mask();
        int k;
        do_reset();
        wr(32'h810, 32'hFEE01000, 4'hF);
        wr(32'h818, 32'h51, 4'hF);
        wr(32'h81C, 32'h0, 4'hF);
        wr(32'h830, 32'hFEE03000, 4'hF);
        wr(32'h834, 32'h1, 4'hF);
        wr(32'h838, 32'h53, 4'hF);
        wr(32'h83C, 32'h0, 4'hF);
        wr(32'h004, 32'h3, 4'hF);
        wr(32'h00C, 32'hA, 4'hF);
        repeat (4) tick();
        rd(32'hC00, 32'hA);
        n_vec++;
        if (irq_q.size() != 0) begin
            n_err++;
            $display("FAIL fmask_hold: got %0d messages while function masked, expected 0", irq_q.size());
        end
        irq_q.delete();
        k = cyc;
        wr(32'h004, 32'h1, 4'hF);
        exp_irq.push_back('{k + 2, 1'b1, 1'b0, 64'h00000000FEE01000, 32'h51});
        exp_irq.push_back('{k + 3, 1'b1, 1'b0, 64'h00000001FEE03000, 32'h53});
        repeat (5) tick();
        rd(32'hC00, 32'h0);
        rd(32'h008, 32'hA);
        n_vec++;
        if (irq_q.size() != exp_irq.size()) begin
            n_err++;
            $display("FAIL fmask_irq_count: got %0d, expected %0d", irq_q.size(), exp_irq.size());
        end else begin
            foreach (irq_q[j]) begin
                n_vec++;
                if (irq_q[j] !== exp_irq[j]) begin
                    n_err++;
                    $display("FAIL fmask_irq: got cyc %0d v %b e %b addr %h data %h, expected cyc %0d v %b e %b addr %h data %h",
                             irq_q[j].cyc, irq_q[j].v, irq_q[j].e, irq_q[j].addr, irq_q[j].data,
                             exp_irq[j].cyc, exp_irq[j].v, exp_irq[j].e, exp_irq[j].addr, exp_irq[j].data);
                end
            end
        end
        for (int w = 0; w < 4 && obs_q.size() < exp_q.size(); w++) tick();
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL fmask_rsp_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            rsp_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL fmask_rd: got data %h ctx %h cyc %0d, expected data %h ctx %h cyc %0d",
                         o.data, o.ctx, o.cyc, e.data, e.ctx, e.cyc);
            end
        end
    endtask

    task automatic test_bad_addr();
        int k;
        do_reset();
        wr(32'h828, 32'h77, 4'hF);
        wr(32'h82C, 32'h0, 4'hF);
        wr(32'h004, 32'h1, 4'hF);
        k = cyc;
        wr(32'h00C, 32'h4, 4'hF);
        exp_irq.push_back('{k + 2, 1'b0, 1'b1, 64'h0, 32'h0});
        repeat (4) tick();
        rd(32'h014, 32'h1);
        rd(32'hC00, 32'h0);
        wr(32'h800, 32'hFEE00002, 4'hF);
        wr(32'h80C, 32'h0, 4'hF);
        k = cyc;
        wr(32'h00C, 32'h1, 4'hF);
        exp_irq.push_back('{k + 2, 1'b0, 1'b1, 64'h0, 32'h0});
        repeat (4) tick();
        rd(32'h014, 32'h2);
        rd(32'hC00, 32'h0);
        n_vec++;
        if (irq_q.size() != exp_irq.size()) begin
            n_err++;
            $display("FAIL badaddr_irq_count: got %0d, expected %0d", irq_q.size(), exp_irq.size());
        end else begin
            foreach (irq_q[j]) begin
                n_vec++;
                if ({irq_q[j].cyc, irq_q[j].v, irq_q[j].e} !== {exp_irq[j].cyc, exp_irq[j].v, exp_irq[j].e}) begin
                    n_err++;
                    $display("FAIL badaddr_irq: got cyc %0d v %b e %b, expected cyc %0d v %b e %b",
                             irq_q[j].cyc, irq_q[j].v, irq_q[j].e,
                             exp_irq[j].cyc, exp_irq[j].v, exp_irq[j].e);
                end
            end
        end
        for (int w = 0; w < 4 && obs_q.size() < exp_q.size(); w++) tick();
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL badaddr_rsp_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            rsp_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL badaddr_rd: got data %h ctx %h cyc %0d, expected data %h ctx %h cyc %0d",
                         o.data, o.ctx, o.cyc, e.data, e.ctx, e.cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        int k;
        do_reset();
        wr(32'h800, 32'hFEE00000, 4'hF);
        wr(32'h808, 32'h99, 4'hF);
        wr(32'h80C, 32'h0, 4'hF);
        wr(32'h004, 32'h1, 4'hF);
        k = cyc;
        wr(32'h00C, 32'h1, 4'hF);
        wr(32'h00C, 32'h1, 4'hF);
        exp_irq.push_back('{k + 2, 1'b1, 1'b0, 64'h00000000FEE00000, 32'h99});
        exp_irq.push_back('{k + 3, 1'b1, 1'b0, 64'h00000000FEE00000, 32'h99});
        repeat (4) tick();
        wr(32'h010, 32'h12345678, 4'hF);
        wr(32'h880, 32'hDEAD, 4'hF);
        rd(32'h000, 32'h201D8086);
        rd(32'h010, 32'h12345678);
        rd(32'h808, 32'h99);
        rd(32'h880, 32'h0);
        rd(32'h018, 32'h0);
        rd(32'h00C, 32'h0);
        rd(32'h004, 32'h1);
        rd(32'hC00, 32'h0);
        n_vec++;
        if (irq_q.size() != exp_irq.size()) begin
            n_err++;
            $display("FAIL b2b_irq_count: got %0d, expected %0d", irq_q.size(), exp_irq.size());
        end else begin
            foreach (irq_q[j]) begin
                n_vec++;
                if (irq_q[j] !== exp_irq[j]) begin
                    n_err++;
                    $display("FAIL b2b_irq: got cyc %0d v %b e %b addr %h data %h, expected cyc %0d v %b e %b addr %h data %h",
                             irq_q[j].cyc, irq_q[j].v, irq_q[j].e, irq_q[j].addr, irq_q[j].data,
                             exp_irq[j].cyc, exp_irq[j].v, exp_irq[j].e, exp_irq[j].addr, exp_irq[j].data);
                end
            end
        end
        for (int w = 0; w < 4 && obs_q.size() < exp_q.size(); w++) tick();
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL b2b_rsp_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            rsp_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL b2b_rd: got data %h ctx %h cyc %0d, expected data %h ctx %h cyc %0d",
                         o.data, o.ctx, o.cyc, e.data, e.ctx, e.cyc);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wr(32'h800, 32'hFEE00000, 4'hF);
        wr(32'h80C, 32'h0, 4'hF);
        wr(32'h004, 32'h1, 4'hF);
        wr(32'h00C, 32'h1, 4'hF);
        rst = 1'b0;
        rd_req_valid = 1'b1; rd_req_addr = 32'h000; rd_req_ctx = {24'($urandom), $urandom, $urandom};
        tick();
        rd_req_valid = 1'b0;
        n_vec++;
        if (rd_rsp_valid !== 1'b0 || irq_q.size() != 0) begin
            n_err++;
            $display("FAIL midreset_discard: got rsp_valid %b messages %0d, expected 0 and 0",
                     rd_rsp_valid, irq_q.size());
        end
        tick();
        rst = 1'b1;
        repeat (4) tick();
        n_vec++;
        if (irq_q.size() != 0 || obs_q.size() != 0) begin
            n_err++;
            $display("FAIL midreset_quiet: got messages %0d responses %0d, expected 0 and 0",
                     irq_q.size(), obs_q.size());
        end
        rd(32'hC00, 32'h0);
        rd(32'h004, 32'h0);
        rd(32'h80C, 32'h1);
        for (int w = 0; w < 4 && obs_q.size() < exp_q.size(); w++) tick();
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL midreset_rsp_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            rsp_t o, e;
            o = obs_q.pop_front(); e = exp_q.pop_front(); n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL midreset_rd: got data %h ctx %h cyc %0d, expected data %h ctx %h cyc %0d",
                         o.data, o.ctx, o.cyc, e.data, e.ctx, e.cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_byte_enables();
        test_status_rw1c();
        test_dispatch();
        test_func_mask();
        test_bad_addr();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
